// File: rtl/mac_hdr_parser_pkg.sv
// Shared constants and FSM encoding for the MAC header parser and its bench.
package mac_hdr_parser_pkg;

    localparam int P_PORT_NUM      = 4;
    localparam int P_MAC_MEM_DEPTH = 1024;
    localparam int MAC_W           = 48;
    localparam int DA_BYTES        = 6;
    localparam int HDR_LAST        = 11;

    typedef enum logic [1:0] {
        sIDLE = 2'd0,
        sHDR  = 2'd1,
        sBODY = 2'd2
    } state_t;

    // I/G bit of the first address byte: set means group (multicast) address.
    function automatic logic is_unicast(input logic [MAC_W-1:0] mac);
        return ~mac[40];
    endfunction

endpackage

// File: rtl/mac_hdr_parser_if.sv
// Receive byte stream plus lookup strobe / learn req-gnt toward the shared MAC table.
interface mac_hdr_parser_if #(
    parameter int W_I = 10,
    parameter int W_P = 2
);
    logic           i_rx_valid;
    logic [7:0]     i_rx_data;
    logic           i_rx_sop;
    logic           i_rx_eop;
    logic           o_da_valid;
    logic [W_I-1:0] o_MAC_DA;
    logic           o_learn_req;
    logic           i_learn_gnt;
    logic [W_I-1:0] o_MAC_SA;
    logic [W_P-1:0] o_port_num;
    logic [7:0]     o_drop_cnt;

    modport slave (
        input  i_rx_valid, i_rx_data, i_rx_sop, i_rx_eop, i_learn_gnt,
        output o_da_valid, o_MAC_DA, o_learn_req, o_MAC_SA, o_port_num, o_drop_cnt
    );

    modport master (
        output i_rx_valid, i_rx_data, i_rx_sop, i_rx_eop, i_learn_gnt,
        input  o_da_valid, o_MAC_DA, o_learn_req, o_MAC_SA, o_port_num, o_drop_cnt
    );
endinterface

// File: rtl/mac_hdr_parser_hash_fold.sv
// Combinational 48-bit -> W_I XOR fold; chunks taken from bit 0 up, top chunk zero-padded.
// Zero latency, no flow control.
module mac_hash_fold #(
    parameter int pMAC_MEM_DEPTH = 1024
) (
    input  logic [47:0]                       i_mac,
    output logic [$clog2(pMAC_MEM_DEPTH)-1:0] o_idx
);
    localparam int W_I   = $clog2(pMAC_MEM_DEPTH);
    localparam int N_CH  = (48 + W_I - 1) / W_I;
    localparam int W_PAD = N_CH * W_I;

    logic [W_PAD-1:0] w_pad;

    assign w_pad = W_PAD'(i_mac);

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            o_idx = o_idx ^ w_pad[k*W_I +: W_I];
        end
    end
endmodule

// File: rtl/mac_hdr_parser.sv
// Per-port DA/SA capture: folded DA lookup pulse and SA learn req/gnt, 1 cycle after byte 11.
// Lookups never stall; a learn colliding with an ungranted pending entry is dropped and counted.
module mac_hdr_parser
    import mac_hdr_parser_pkg::*;
#(
    parameter int pPORT_NUM      = P_PORT_NUM,
    parameter int pMAC_MEM_DEPTH = P_MAC_MEM_DEPTH,
    parameter int pPORT_ID       = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mac_hdr_parser_if.slave bus
);
    localparam int W_I = $clog2(pMAC_MEM_DEPTH);
    localparam int W_P = $clog2(pPORT_NUM);

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [47:0]    r_da;
    logic [39:0]    r_sa;
    logic           r_da_vld;
    logic [W_I-1:0] r_da_idx;
    logic [W_I-1:0] r_sa_idx;
    logic           r_req;
    logic [7:0]     r_drop;

    logic           w_hdr_done;
    logic           w_learn;
    logic [47:0]    w_sa_full;
    logic [W_I-1:0] w_da_idx;
    logic [W_I-1:0] w_sa_idx;

    // SA's last byte is still on the bus when the header completes, so fold it in directly.
    assign w_sa_full  = {r_sa, bus.i_rx_data};
    assign w_hdr_done = bus.i_rx_valid && !bus.i_rx_sop && (r_state == sHDR)
                        && (r_cnt == 4'(HDR_LAST));
    assign w_learn    = w_hdr_done && is_unicast(w_sa_full);

    mac_hash_fold #(.pMAC_MEM_DEPTH(pMAC_MEM_DEPTH)) u_fold_da (
        .i_mac (r_da),
        .o_idx (w_da_idx)
    );

    mac_hash_fold #(.pMAC_MEM_DEPTH(pMAC_MEM_DEPTH)) u_fold_sa (
        .i_mac (w_sa_full),
        .o_idx (w_sa_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= sIDLE;
            r_cnt    <= '0;
            r_da     <= '0;
            r_sa     <= '0;
            r_da_vld <= 1'b0;
            r_da_idx <= '0;
            r_sa_idx <= '0;
            r_req    <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_da_vld <= w_hdr_done;
            if (w_hdr_done) begin
                r_da_idx <= w_da_idx;
            end

            // A same-cycle grant retires the old entry, so the new one may take its place.
            if (w_learn) begin
                if (!r_req || bus.i_learn_gnt) begin
                    r_req    <= 1'b1;
                    r_sa_idx <= w_sa_idx;
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end else if (r_req && bus.i_learn_gnt) begin
                r_req <= 1'b0;
            end

            if (bus.i_rx_valid && bus.i_rx_sop) begin
                r_da    <= {r_da[39:0], bus.i_rx_data};
                r_cnt   <= 4'd1;
                r_state <= bus.i_rx_eop ? sIDLE : sHDR;
            end else if (bus.i_rx_valid) begin
                case (r_state)
                    sHDR: begin
                        if (r_cnt < 4'(DA_BYTES)) begin
                            r_da <= {r_da[39:0], bus.i_rx_data};
                        end else begin
                            r_sa <= {r_sa[31:0], bus.i_rx_data};
                        end
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'(HDR_LAST)) begin
                            r_state <= bus.i_rx_eop ? sIDLE : sBODY;
                        end else if (bus.i_rx_eop) begin
                            r_state <= sIDLE;
                        end
                    end
                    sBODY: begin
                        if (bus.i_rx_eop) begin
                            r_state <= sIDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_da_valid  = r_da_vld;
    assign bus.o_MAC_DA    = r_da_idx;
    assign bus.o_learn_req = r_req;
    assign bus.o_MAC_SA    = r_sa_idx;
    assign bus.o_port_num  = W_P'(pPORT_ID);
    assign bus.o_drop_cnt  = r_drop;
endmodule

// File: tb/tb_mac_hdr_parser.sv
// Bench for mac_hdr_parser: vector table, hand-written corner sequences, random frames vs. a frame-level model.
module tb_mac_hdr_parser;
    import mac_hdr_parser_pkg::*;

    logic i_clk;
    logic i_rst_n;

    mac_hdr_parser_if #(.W_I(10), .W_P(2)) bus ();

    mac_hdr_parser #(
        .pPORT_NUM      (4),
        .pMAC_MEM_DEPTH (1024),
        .pPORT_ID       (2)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [9:0] mon_da_q[$];
    logic [9:0] mon_sa_q[$];
    logic [9:0] exp_da_q[$];
    logic [9:0] exp_sa_q[$];

    typedef struct {
        logic [47:0] da;
        logic [47:0] sa;
        int          len;
        bit          exp_hdr;
        logic [9:0]  exp_da;
        bit          exp_learn;
        logic [9:0]  exp_sa;
    } vec_t;

    vec_t tbl[6];

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (bus.o_da_valid) mon_da_q.push_back(bus.o_MAC_DA);
            if (bus.o_learn_req && bus.i_learn_gnt) mon_sa_q.push_back(bus.o_MAC_SA);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Index model: XOR of successive 10-bit slices of the address value.
    function automatic logic [9:0] fold_ref(input logic [47:0] a);
        logic [63:0] v;
        logic [9:0]  r;
        v = {16'd0, a};
        r = '0;
        while (v != 64'd0) begin
            r = r ^ v[9:0];
            v = v >> 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [47:0] da, input logic [47:0] sa, input int i);
        if (i < 6)  return da[47-8*i -: 8];
        if (i < 12) return sa[47-8*(i-6) -: 8];
        return 8'($urandom);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic sop, input logic eop, input int gap_pct);
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            bus.i_rx_valid = 1'b0;
            bus.i_rx_data  = 8'($urandom);
            bus.i_rx_sop   = 1'($urandom);
            bus.i_rx_eop   = 1'($urandom);
            tick();
        end
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = d;
        bus.i_rx_sop   = sop;
        bus.i_rx_eop   = eop;
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_sop   = 1'b0;
        bus.i_rx_eop   = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] da, input logic [47:0] sa, input int len,
                              input bit eop_en, input int gap_pct);
        for (int i = 0; i < len; i++)
            drive_byte(frame_byte(da, sa, i), i == 0, eop_en && (i == len - 1), gap_pct);
    endtask

    task automatic idle(input int n);
        bus.i_rx_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_q();
        mon_da_q.delete(); mon_sa_q.delete();
        exp_da_q.delete(); exp_sa_q.delete();
    endtask

    task automatic check_queues(input string tag);
        chk({tag, "_n_da"}, mon_da_q.size(), exp_da_q.size());
        if (mon_da_q.size() == exp_da_q.size())
            foreach (exp_da_q[i]) chk({tag, "_da_idx"}, int'(mon_da_q[i]), int'(exp_da_q[i]));
        chk({tag, "_n_learn"}, mon_sa_q.size(), exp_sa_q.size());
        if (mon_sa_q.size() == exp_sa_q.size())
            foreach (exp_sa_q[i]) chk({tag, "_sa_idx"}, int'(mon_sa_q[i]), int'(exp_sa_q[i]));
        clear_q();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_da_valid"}, int'(bus.o_da_valid), 0);
        chk({tag, "_mac_da"},   int'(bus.o_MAC_DA), 0);
        chk({tag, "_req"},      int'(bus.o_learn_req), 0);
        chk({tag, "_mac_sa"},   int'(bus.o_MAC_SA), 0);
        chk({tag, "_drop"},     int'(bus.o_drop_cnt), 0);
    endtask

    initial begin
        logic [47:0] da, sa;
        int          len;
        bit          eop_en;

        tbl[0] = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 64, 1'b1, 10'h0FF, 1'b1, 10'h001};
        tbl[1] = '{48'h0100_5E00_0001, 48'h0100_5E00_0001, 60, 1'b1, 10'h1E1, 1'b0, 10'h000};
        tbl[2] = '{48'h0011_2233_4455, 48'h02AA_BBCC_DDEE, 10, 1'b0, 10'h000, 1'b0, 10'h000};
        tbl[3] = '{48'h0011_2233_4455, 48'h02AA_BBCC_DDEE, 12, 1'b1, 10'h2E3, 1'b1, 10'h3CD};
        tbl[4] = '{48'h0100_5E00_0001, 48'h0011_2233_4455, 40, 1'b1, 10'h1E1, 1'b1, 10'h2E3};
        tbl[5] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,  1, 1'b0, 10'h000, 1'b0, 10'h000};

        i_rst_n         = 1'b0;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_data   = '0;
        bus.i_rx_sop    = 1'b0;
        bus.i_rx_eop    = 1'b0;
        bus.i_learn_gnt = 1'b0;
        #3;
        chk_outputs_zero("reset");
        chk("port_num", int'(bus.o_port_num), 2);
        tick(); tick();
        i_rst_n = 1'b1;
        idle(2);

        // Lookup and learn both appear in the cycle right after byte 11.
        bus.i_learn_gnt = 1'b1;
        da = 48'hFFFF_FFFF_FFFF;
        sa = 48'h0000_0000_0001;
        for (int i = 0; i < 12; i++) drive_byte(frame_byte(da, sa, i), i == 0, 1'b0, 0);
        #2;
        chk("t1_da_valid", int'(bus.o_da_valid), 1);
        chk("t1_mac_da",   int'(bus.o_MAC_DA), 'h0FF);
        chk("t1_req",      int'(bus.o_learn_req), 1);
        chk("t1_mac_sa",   int'(bus.o_MAC_SA), 'h001);
        drive_byte(8'h5A, 1'b0, 1'b0, 0);
        #2;
        chk("t1_da_valid_pulse", int'(bus.o_da_valid), 0);
        chk("t1_req_after_gnt",  int'(bus.o_learn_req), 0);
        for (int i = 13; i < 64; i++) drive_byte(8'($urandom), 1'b0, i == 63, 0);
        idle(2);
        clear_q();

        foreach (tbl[k]) begin
            send_frame(tbl[k].da, tbl[k].sa, tbl[k].len, 1'b1, 0);
            idle(3);
            if (tbl[k].exp_hdr)   exp_da_q.push_back(tbl[k].exp_da);
            if (tbl[k].exp_learn) exp_sa_q.push_back(tbl[k].exp_sa);
            check_queues($sformatf("tbl%0d", k));
        end

        // Frame A is cut by a sop at its byte 7; only frame B may produce strobes.
        send_frame(48'h0011_2233_4455, 48'hFFFF_FFFF_FFFF, 7, 1'b0, 0);
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 20, 1'b1, 0);
        idle(3);
        exp_da_q.push_back(10'h0FF);
        exp_sa_q.push_back(10'h001);
        check_queues("t5_abort");

        for (int f = 0; f < 60; f++) begin
            da     = {16'($urandom), $urandom};
            sa     = {16'($urandom), $urandom};
            len    = $urandom_range(1, 30);
            eop_en = ($urandom_range(0, 4) != 0);
            if (len >= 12) begin
                exp_da_q.push_back(fold_ref(da));
                if (sa[40] == 1'b0) exp_sa_q.push_back(fold_ref(sa));
            end
            send_frame(da, sa, len, eop_en, 30);
            if (eop_en) begin
                repeat ($urandom_range(0, 3)) drive_byte(8'($urandom), 1'b0, 1'($urandom), 20);
            end
            idle(2);
            check_queues("rnd");
        end
        chk("rnd_drop", int'(bus.o_drop_cnt), 0);

        // Ungranted entry is held; the colliding second entry is dropped.
        bus.i_learn_gnt = 1'b0;
        send_frame(48'h0011_2233_4455, 48'h02AA_BBCC_DDEE, 20, 1'b1, 0);
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 20, 1'b1, 0);
        idle(1);
        chk("t4_req_held", int'(bus.o_learn_req), 1);
        chk("t4_sa_held",  int'(bus.o_MAC_SA), 'h3CD);
        chk("t4_drop",     int'(bus.o_drop_cnt), 1);
        bus.i_learn_gnt = 1'b1;
        tick();
        bus.i_learn_gnt = 1'b0;
        #2;
        chk("t4_req_drop", int'(bus.o_learn_req), 0);
        idle(2);
        clear_q();

        // Grant in the very cycle a new header completes: new entry replaces old, no drop.
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 16, 1'b1, 0);
        for (int i = 0; i < 12; i++) begin
            bus.i_learn_gnt = (i == 11);
            drive_byte(frame_byte(48'h0011_2233_4455, 48'h02AA_BBCC_DDEE, i), i == 0, 1'b0, 0);
        end
        bus.i_learn_gnt = 1'b0;
        #2;
        chk("swap_req",  int'(bus.o_learn_req), 1);
        chk("swap_sa",   int'(bus.o_MAC_SA), 'h3CD);
        chk("swap_drop", int'(bus.o_drop_cnt), 1);
        drive_byte(8'h00, 1'b0, 1'b1, 0);

        for (int f = 0; f < 260; f++)
            send_frame(48'h0100_5E00_0001, 48'h0011_2233_4455, 12, 1'b1, 0);
        idle(1);
        chk("sat_drop", int'(bus.o_drop_cnt), 255);
        chk("sat_sa",   int'(bus.o_MAC_SA), 'h3CD);
        chk("sat_req",  int'(bus.o_learn_req), 1);

        // Reset lands mid-header while a learn is still pending.
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom), i == 0, 1'b0, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_async");
        idle(2);
        i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive_byte(8'($urandom), 1'b0, 1'b0, 0);
        idle(2);
        chk("t6_no_sop_ignored", int'(bus.o_da_valid) + int'(bus.o_learn_req), 0);
        clear_q();
        bus.i_learn_gnt = 1'b1;
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 64, 1'b1, 0);
        idle(3);
        exp_da_q.push_back(10'h0FF);
        exp_sa_q.push_back(10'h001);
        check_queues("t6_after");
        chk("t6_drop", int'(bus.o_drop_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
